// File: rtl/sfx_sequencer.sv
// Priority sound-effect sequencer: latches collision triggers and plays swept square-wave tones, one effect at a time.
// Optional build macro SFX_NOISE_EN: channel 0 plays LFSR noise instead of a square wave.
module sfx_sequencer #(
    parameter int NUM_CH    = 3,
    parameter int DIV_W     = 12,
    parameter int TONE_BASE = 800,
    parameter int TONE_STEP = 200,
    parameter int SWEEP     = 8,
    parameter int DUR       = 8,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] event_trig,
    input  logic              frame_end,
    output logic              sound,
    output logic              busy,
    output logic [CH_W-1:0]   cur_ch
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [DIV_W-1:0]  hp_q, hp_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        frames_q, frames_d;
    logic              sound_q, sound_d;
`ifdef SFX_NOISE_EN
    logic [15:0]       lfsr_q, lfsr_d;
`endif

    logic [CH_W-1:0]   top_ch;
    logic              any_pending;
    logic              do_load;
    logic [NUM_CH-1:0] pend_clr;

    // Highest set index wins; index 0 is the lowest priority.
    function automatic logic [CH_W-1:0] top_idx(input logic [NUM_CH-1:0] p);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (p[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    // Starting half-period for a channel, wrapped to the divider width; zero would stall the tone.
    function automatic logic [DIV_W-1:0] load_hp(input logic [CH_W-1:0] c);
        logic [31:0]      raw;
        logic [DIV_W-1:0] hp;
        raw = 32'(TONE_BASE) + 32'(TONE_STEP) * 32'(c);
        hp  = raw[DIV_W-1:0];
        return (hp == '0) ? DIV_W'(1) : hp;
    endfunction

    // Pitch sweep with saturation at 1 so a large step never wraps to a long period.
    function automatic logic [DIV_W-1:0] sweep_hp(input logic [DIV_W-1:0] hp);
        logic signed [32:0] diff;
        diff = $signed({{(33-DIV_W){1'b0}}, hp}) - 33'(SWEEP);
        if (diff < 33'sd1) return DIV_W'(1);
        return diff[DIV_W-1:0];
    endfunction

`ifdef SFX_NOISE_EN
    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction
`endif

    assign top_ch      = top_idx(pending_q);
    assign any_pending = |pending_q;

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        hp_d     = hp_q;
        cnt_d    = cnt_q;
        frames_d = frames_q;
        sound_d  = sound_q;
        do_load  = 1'b0;
        pend_clr = '0;
`ifdef SFX_NOISE_EN
        lfsr_d   = lfsr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (any_pending) do_load = 1'b1;
            end
            S_PLAY: begin
                if (any_pending && (top_ch > cur_ch_q)) begin
                    do_load = 1'b1;
                end else begin
                    // >= rather than == keeps the wrap prompt when a sweep shortens the period below the count.
                    if (cnt_q >= hp_q - DIV_W'(1)) begin
                        cnt_d = '0;
`ifdef SFX_NOISE_EN
                        if (cur_ch_q == '0) begin
                            lfsr_d  = lfsr_step(lfsr_q);
                            sound_d = lfsr_d[0];
                        end else begin
                            sound_d = ~sound_q;
                        end
`else
                        sound_d = ~sound_q;
`endif
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                    if (frame_end) begin
                        hp_d     = sweep_hp(hp_q);
                        frames_d = frames_q - 4'd1;
                        if (frames_q <= 4'd1) begin
                            state_d = S_GAP;
                            sound_d = 1'b0;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            S_GAP: begin
                sound_d = 1'b0;
                if (frame_end) begin
                    state_d  = S_IDLE;
                    cur_ch_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cur_ch_d = '0;
                sound_d  = 1'b0;
            end
        endcase

        if (do_load) begin
            state_d          = S_PLAY;
            cur_ch_d         = top_ch;
            hp_d             = load_hp(top_ch);
            cnt_d            = '0;
            sound_d          = 1'b0;
            frames_d         = 4'(DUR);
            pend_clr[top_ch] = 1'b1;
        end

        // A trigger arriving on its own load edge re-arms the channel for a replay.
        pending_d = (pending_q & ~pend_clr) | event_trig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            cur_ch_q  <= '0;
            hp_q      <= '0;
            cnt_q     <= '0;
            frames_q  <= '0;
            sound_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cur_ch_q  <= cur_ch_d;
            hp_q      <= hp_d;
            cnt_q     <= cnt_d;
            frames_q  <= frames_d;
            sound_q   <= sound_d;
        end
    end

`ifdef SFX_NOISE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`endif

    assign sound  = sound_q;
    assign busy   = (state_q != S_IDLE);
    assign cur_ch = cur_ch_q;

endmodule
